// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared types and defaults for the unified-memory arbiter.
//   size_e      - load/store access size encoding (as driven on d_size)
//   arb_state_e - arbiter FSM state encoding
//   MAX_WAIT_DEF- default bound on cycles a pending fetch may lose arbitration
package rv_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_F = 2'b01,
    BUSY_D = 2'b10,
    ERR_D  = 2'b11
  } arb_state_e;

  localparam int unsigned MAX_WAIT_DEF = 4;

endpackage

// File: rtl/rv_lane_align.sv
// rv_lane_align: combinational byte-lane alignment for 32-bit memory words.
// Request side:
//   size, off     - access size and byte offset within the word
//   wdata_in      - right-justified store data
//   be            - byte enables
//   wdata_lane    - store data replicated onto all lanes of its size
//   misalign      - misaligned half/word or illegal size
// Response side:
//   rd_size, rd_off - size/offset of the access being completed
//   rdata_in        - raw memory word
//   rdata_out       - right-justified, zero-extended load data
module rv_lane_align
  import rv_mem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic        misalign,
  input  size_e       rd_size,
  input  logic [1:0]  rd_off,
  input  logic [31:0] rdata_in,
  output logic [31:0] rdata_out
);

  logic [31:0] rd_shifted;

  always_comb begin
    be         = '0;
    wdata_lane = '0;
    misalign   = 1'b0;
    case (size)
      SZ_B: begin
        be         = 4'b0001 << off;
        wdata_lane = {4{wdata_in[7:0]}};
      end
      SZ_H: begin
        be         = 4'b0011 << off;
        wdata_lane = {2{wdata_in[15:0]}};
        misalign   = off[0];
      end
      SZ_W: begin
        be         = '1;
        wdata_lane = wdata_in;
        misalign   = |off;
      end
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    rd_shifted = rdata_in >> {rd_off, 3'b000};
    case (rd_size)
      SZ_B:    rdata_out = {24'h0, rd_shifted[7:0]};
      SZ_H:    rdata_out = {16'h0, rd_shifted[15:0]};
      default: rdata_out = rd_shifted;
    endcase
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one unified instruction/data memory between the
// fetch port (f_*) and the load/store port (d_*), one transaction at a time.
// Data normally wins arbitration; a fetch that has lost MAX_WAIT cycles gets
// priority. Misaligned/illegal data accesses are answered with d_err without
// touching memory.
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   f_req/f_addr/f_gnt              - fetch request handshake (word reads)
//   f_rvalid/f_rdata                - fetch response pulse and data
//   d_req/d_we/d_size/d_addr/d_wdata- data request
//   d_gnt                           - data request accepted
//   d_rvalid/d_rdata/d_err          - data response pulse, load data, error
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata - memory request (held to ack)
//   mem_rdata/mem_ack               - memory response
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned WCNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_SAT = WCNT_W'(MAX_WAIT);

  arb_state_e state_q, state_d;
  logic [WCNT_W-1:0] wait_q;

  logic              lat_we;
  logic [3:0]        lat_be;
  logic [ADDR_W-3:0] lat_addr;
  logic [31:0]       lat_wdata;
  size_e             lat_size;
  logic [1:0]        lat_off;

  logic              f_rvalid_q, d_rvalid_q;
  logic [31:0]       f_rdata_q, d_rdata_q;

  logic [3:0]        d_be;
  logic [31:0]       d_wlane, ld_data;
  logic              d_misalign;
  logic              idle, busy, f_win;
  logic              f_addr_unused;

  // Fetch is always a word access, so its low address bits carry nothing.
  assign f_addr_unused = ^f_addr[1:0];

  rv_lane_align u_align (
    .size       (size_e'(d_size)),
    .off        (d_addr[1:0]),
    .wdata_in   (d_wdata),
    .be         (d_be),
    .wdata_lane (d_wlane),
    .misalign   (d_misalign),
    .rd_size    (lat_size),
    .rd_off     (lat_off),
    .rdata_in   (mem_rdata),
    .rdata_out  (ld_data)
  );

  assign idle  = (state_q == IDLE);
  assign busy  = (state_q == BUSY_F) || (state_q == BUSY_D);
  // Fetch wins only when data is absent or the fetch has waited long enough.
  assign f_win = f_req && (!d_req || (wait_q == WAIT_SAT));

  // Grants are masked during reset so every output reads 0 while rst_n is low.
  assign f_gnt = rst_n && idle && f_win;
  assign d_gnt = rst_n && idle && d_req && !f_win;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (f_gnt)      state_d = BUSY_F;
        else if (d_gnt) state_d = d_misalign ? ERR_D : BUSY_D;
      end
      BUSY_F, BUSY_D: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                           wait_q <= '0;
    else if (f_gnt)                       wait_q <= '0;
    else if (f_req && wait_q != WAIT_SAT) wait_q <= wait_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_size  <= SZ_W;
      lat_off   <= '0;
    end else if (f_gnt) begin
      lat_we    <= 1'b0;
      lat_be    <= '1;
      lat_addr  <= f_addr[ADDR_W-1:2];
      lat_wdata <= '0;
      lat_size  <= SZ_W;
      lat_off   <= '0;
    end else if (d_gnt) begin
      lat_we    <= d_we;
      lat_be    <= d_be;
      lat_addr  <= d_addr[ADDR_W-1:2];
      lat_wdata <= d_wlane;
      lat_size  <= size_e'(d_size);
      lat_off   <= d_addr[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      f_rvalid_q <= (state_q == BUSY_F) && mem_ack;
      d_rvalid_q <= (state_q == BUSY_D) && mem_ack;
      if ((state_q == BUSY_F) && mem_ack) f_rdata_q <= mem_rdata;
      if ((state_q == BUSY_D) && mem_ack) d_rdata_q <= lat_we ? '0 : ld_data;
    end
  end

  assign mem_req   = busy;
  assign mem_we    = busy && lat_we;
  assign mem_be    = busy ? lat_be    : '0;
  assign mem_addr  = busy ? lat_addr  : '0;
  assign mem_wdata = busy ? lat_wdata : '0;

  assign f_rvalid  = f_rvalid_q;
  assign f_rdata   = f_rdata_q;
  assign d_err     = (state_q == ERR_D);
  assign d_rvalid  = d_rvalid_q || d_err;
  assign d_rdata   = d_err ? '0 : d_rdata_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
module tb_rv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req;
  logic [6:0]  f_addr;
  logic        f_gnt, f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req, d_we;
  logic [1:0]  d_size;
  logic [6:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.ADDR_W(7), .MAX_WAIT(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Advance to the next falling edge; inputs are changed right after it.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;

    // Reset state
    tick(); tick(); #1;
    check("rst_mem", {27'(0), mem_req, mem_we, mem_be[2:0]} | {28'(0), mem_be}, 32'h0);
    check("rst_maddr", {27'(0), mem_addr}, 32'h0);
    check("rst_mwdata", mem_wdata, 32'h0);
    check("rst_hs", {26'(0), f_gnt, f_rvalid, d_gnt, d_rvalid, d_err, 1'b0}, 32'h0);
    check("rst_rdata", f_rdata | d_rdata, 32'h0);

    // 1: fetch only
    tick(); rst_n = 1'b1; f_req = 1'b1; f_addr = 7'h04; #1;
    check("t1_fgnt", {31'(0), f_gnt}, 32'h1);
    tick(); f_req = 1'b0; #1;
    check("t1_mreq", {31'(0), mem_req}, 32'h1);
    check("t1_maddr", {27'(0), mem_addr}, 32'h1);
    check("t1_be_we", {27'(0), mem_we, mem_be}, 32'h0F);
    tick(); mem_ack = 1'b1; mem_rdata = 32'h00A00093; #1;
    check("t1_mreq_hold", {31'(0), mem_req}, 32'h1);
    tick(); mem_ack = 1'b0; mem_rdata = '0; #1;
    check("t1_frvalid", {31'(0), f_rvalid}, 32'h1);
    check("t1_frdata", f_rdata, 32'h00A00093);
    check("t1_mreq_drop", {31'(0), mem_req}, 32'h0);
    tick(); #1;
    check("t1_frvalid_pulse", {31'(0), f_rvalid}, 32'h0);

    // 2: simultaneous fetch and SW 0xDEADBEEF @0x10
    f_req = 1'b1; f_addr = 7'h08;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 7'h10; d_wdata = 32'hDEADBEEF; #1;
    check("t2_gnt", {30'(0), f_gnt, d_gnt}, 32'h1);
    tick(); d_req = 1'b0; #1;
    check("t2_mem", {26'(0), mem_req, mem_we, mem_be}, 32'h3F);
    check("t2_maddr", {27'(0), mem_addr}, 32'h4);
    check("t2_mwdata", mem_wdata, 32'hDEADBEEF);
    check("t2_fgnt_busy", {31'(0), f_gnt}, 32'h0);
    tick(); mem_ack = 1'b1; #1;
    tick(); mem_ack = 1'b0; #1;
    check("t2_drv", {29'(0), d_rvalid, d_err, f_rvalid}, 32'h4);
    check("t2_drdata", d_rdata, 32'h0);
    check("t2_fgnt_next", {31'(0), f_gnt}, 32'h1);
    tick(); f_req = 1'b0; #1;
    check("t2_faddr", {26'(0), mem_req, mem_addr}, 32'h22);
    tick(); mem_ack = 1'b1; mem_rdata = 32'h11223344; #1;
    tick(); mem_ack = 1'b0; #1;
    check("t2_frdata", f_rdata, 32'h11223344);

    // 3a: SB 0xAB @0x13
    tick(); d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 7'h13; d_wdata = 32'h000000AB; #1;
    check("t3_sb_gnt", {31'(0), d_gnt}, 32'h1);
    tick(); d_req = 1'b0; #1;
    check("t3_sb_be", {27'(0), mem_we, mem_be}, 32'h18);
    check("t3_sb_wdata", mem_wdata, 32'hABABABAB);
    tick(); mem_ack = 1'b1; #1;
    tick(); mem_ack = 1'b0; #1;
    check("t3_sb_rv", {31'(0), d_rvalid}, 32'h1);
    // 3b: LH @0x12
    tick(); d_req = 1'b1; d_we = 1'b0; d_size = 2'b01; d_addr = 7'h12; #1;
    check("t3_lh_gnt", {31'(0), d_gnt}, 32'h1);
    tick(); d_req = 1'b0; #1;
    check("t3_lh_be", {26'(0), mem_req, mem_we, mem_be}, 32'h2C);
    check("t3_lh_addr", {27'(0), mem_addr}, 32'h4);
    tick(); mem_ack = 1'b1; mem_rdata = 32'h80010000; #1;
    tick(); mem_ack = 1'b0; #1;
    check("t3_lh_rv", {30'(0), d_rvalid, d_err}, 32'h2);
    check("t3_lh_rdata", d_rdata, 32'h00008001);

    // 4: misaligned LW @0x06
    tick(); d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 7'h06; #1;
    check("t4_gnt", {31'(0), d_gnt}, 32'h1);
    tick(); d_req = 1'b0; #1;
    check("t4_err", {29'(0), d_rvalid, d_err, mem_req}, 32'h6);
    check("t4_rdata", d_rdata, 32'h0);
    tick(); #1;
    check("t4_after", {29'(0), d_rvalid, d_err, mem_req}, 32'h0);

    // 5: starvation bound with MAX_WAIT=2, d_req held high throughout
    f_req = 1'b1; f_addr = 7'h0C;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 7'h20; #1;
    check("t5_d_first", {30'(0), f_gnt, d_gnt}, 32'h1);
    tick(); #1;
    check("t5_busy", {29'(0), mem_req, f_gnt, d_gnt}, 32'h4);
    tick(); mem_ack = 1'b1; mem_rdata = 32'h12345678; #1;
    tick(); mem_ack = 1'b0; #1;
    check("t5_f_wins", {30'(0), f_gnt, d_gnt}, 32'h2);
    check("t5_ld", d_rdata, 32'h12345678);
    tick(); f_req = 1'b0; #1;
    check("t5_faddr", {26'(0), mem_req, mem_addr}, 32'h23);
    tick(); mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
    tick(); mem_ack = 1'b0; #1;
    check("t5_frv", {31'(0), f_rvalid}, 32'h1);
    check("t5_d_again", {31'(0), d_gnt}, 32'h1);

    // 6: reset while BUSY_D, then a late ack
    tick(); d_req = 1'b0; rst_n = 1'b0; #1;
    check("t6_busy", {31'(0), mem_req}, 32'h1);
    tick(); rst_n = 1'b1; mem_ack = 1'b1; #1;
    check("t6_mreq_drop", {30'(0), mem_req, d_rvalid}, 32'h0);
    tick(); mem_ack = 1'b0; #1;
    check("t6_no_rv", {29'(0), d_rvalid, f_rvalid, mem_req}, 32'h0);
    tick(); #1;
    check("t6_idle", {29'(0), d_rvalid, d_err, mem_req}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
